// File: rtl/bat_level_ctrl_if.sv
// Command handshake between a host sequencer and the battery bar-level controller.
// The master issues SET/INC/DEC/SWEEP requests; the slave accepts them while idle.
interface bat_level_ctrl_if;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic [4:0] cmd_level;
    logic       cmd_ready;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_level,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_level,
        output cmd_ready
    );
endinterface

// File: rtl/bat_level_ctrl.sv
// Battery bar-level controller: steps a displayed level toward a commanded target,
// one segment per STEP_FRAMES frame ticks, and drives a registered thermometer bar.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// ST_IDLE     | waiting for a command; frame ticks ignored
// ST_MOVE     | stepping level by one toward target each STEP_FRAMES ticks
// ST_SWEEP_DN | sweep phase 1: stepping level down to 0
// ST_SWEEP_UP | sweep phase 2: stepping level up to MAX_LEVEL, then back to target
module bat_level_ctrl #(
    parameter int MAX_LEVEL   = 28,
    parameter int STEP_FRAMES = 4,
    parameter int LOW_THRESH  = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frame_tick,
    bat_level_ctrl_if.slave      cmd_if,
    output logic [MAX_LEVEL-1:0] bat,
    output logic [4:0]           level,
    output logic                 busy,
    output logic                 done,
    output logic                 low
);

    localparam int CW = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
    localparam logic [CW-1:0] STEP_M1 = CW'(STEP_FRAMES - 1);
    localparam logic [4:0] MAX_L = 5'(MAX_LEVEL);
    localparam logic [4:0] LOW_L = 5'(LOW_THRESH);

    localparam logic [1:0] OP_SET   = 2'b00;
    localparam logic [1:0] OP_INC   = 2'b01;
    localparam logic [1:0] OP_DEC   = 2'b10;
    localparam logic [1:0] OP_SWEEP = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MOVE     = 2'd1,
        ST_SWEEP_DN = 2'd2,
        ST_SWEEP_UP = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [4:0]           level_q, level_d;
    logic [4:0]           target_q, target_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 done_q, done_d;
    logic [MAX_LEVEL-1:0] bat_q, bat_d;
    logic                 low_q, low_d;

    logic                 step_due;
    logic [4:0]           cmd_tgt;
    logic                 noop_accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            level_q  <= '0;
            target_q <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            bat_q    <= '0;
            low_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            bat_q    <= bat_d;
            low_q    <= low_d;
        end
    end

    // Target for the three level-setting ops; clamped so level can never leave 0..MAX_LEVEL.
    always_comb begin
        cmd_tgt = level_q;
        unique case (cmd_if.cmd_op)
            OP_SET:   cmd_tgt = (cmd_if.cmd_level > MAX_L) ? MAX_L : cmd_if.cmd_level;
            OP_INC:   cmd_tgt = (level_q >= MAX_L) ? MAX_L : level_q + 5'd1;
            OP_DEC:   cmd_tgt = (level_q == 5'd0) ? 5'd0 : level_q - 5'd1;
            OP_SWEEP: cmd_tgt = level_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        target_d    = target_q;
        cnt_d       = cnt_q;
        noop_accept = 1'b0;
        step_due    = frame_tick && (cnt_q == STEP_M1);

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (cmd_if.cmd_valid) begin
                    target_d = cmd_tgt;
                    if (cmd_if.cmd_op == OP_SWEEP) begin
                        state_d = ST_SWEEP_DN;
                    end else if (cmd_tgt == level_q) begin
                        noop_accept = 1'b1;
                    end else begin
                        state_d = ST_MOVE;
                    end
                end
            end

            ST_MOVE: begin
                if (level_q == target_q) begin
                    state_d = ST_IDLE;
                end else if (frame_tick) begin
                    if (step_due) begin
                        cnt_d   = '0;
                        level_d = (level_q < target_q) ? level_q + 5'd1 : level_q - 5'd1;
                        if (level_d == target_q) begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            ST_SWEEP_DN: begin
                if (level_q == 5'd0) begin
                    state_d = ST_SWEEP_UP;
                end else if (frame_tick) begin
                    if (step_due) begin
                        cnt_d   = '0;
                        level_d = level_q - 5'd1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            ST_SWEEP_UP: begin
                // Reaching full scale hands back to MOVE so the level returns to the saved target.
                if (level_q >= MAX_L) begin
                    state_d = (target_q == MAX_L) ? ST_IDLE : ST_MOVE;
                end else if (frame_tick) begin
                    if (step_due) begin
                        cnt_d   = '0;
                        level_d = level_q + 5'd1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
        endcase

        done_d = noop_accept || ((state_q != ST_IDLE) && (state_d == ST_IDLE));
    end

    // Bar and low flag follow the level register with one cycle of latency.
    always_comb begin
        bat_d = '0;
        for (int i = 0; i < MAX_LEVEL; i++) begin
            bat_d[i] = (5'(i) < level_q);
        end
        low_d = (level_q <= LOW_L);
    end

    assign cmd_if.cmd_ready = (state_q == ST_IDLE);
    assign bat              = bat_q;
    assign level            = level_q;
    assign busy             = (state_q != ST_IDLE);
    assign done             = done_q;
    assign low              = low_q;

endmodule
